alu_system_controller: RTL

Hardwired control unit for ALU_System. Fetches 16-bit instructions from memory into the IR as two byte reads, decodes them and drives every ALU_System control input cycle by cycle. It replaces the hand-written test vector stream as the source of RF, ARF, ALU, IR, memory and mux selects. IROut is its only datapath input.

---
 rtl/alu_system_controller.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/alu_system_controller.sv
// Hardwired control unit for ALU_System: fetches a 16-bit instruction as two
// byte reads into the IR, then decodes and drives every datapath select.
module alu_system_controller (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RSel,
  output logic [3:0]  RF_TSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [3:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Enable,
  output logic [1:0]  IR_Funsel,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic        Halted,
  output logic [2:0]  SeqState,
  output logic [7:0]  InstrCount
);

  localparam logic [2:0] S_INIT    = 3'd0;
  localparam logic [2:0] S_FETCH_L = 3'd1;
  localparam logic [2:0] S_FETCH_H = 3'd2;
  localparam logic [2:0] S_EXEC0   = 3'd3;
  localparam logic [2:0] S_EXEC1   = 3'd4;
  localparam logic [2:0] S_HALT    = 3'd5;

  localparam logic [3:0] OP_LDI = 4'h0;
  localparam logic [3:0] OP_LDM = 4'h1;
  localparam logic [3:0] OP_STM = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_BRA = 4'h4;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [2:0] state;
  logic [2:0] next_state;
  logic [2:0] decode_state;
  logic [7:0] instr_count;
  logic       halted;
  logic       retire;
  logic [3:0] opcode;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [3:0] rd_onehot;
  logic       unused_imm;

  assign opcode     = IROut[15:12];
  assign rd         = IROut[11:10];
  assign rs         = IROut[9:8];
  assign rd_onehot  = 4'b1000 >> rd;
  assign unused_imm = ^IROut[7:0];

  // While Reset is held the outputs show the INIT (clear-all) decode.
  assign decode_state = Reset ? S_INIT : state;

  assign retire = ((state == S_EXEC0) || (state == S_EXEC1)) &&
                  ((next_state == S_FETCH_L) || (next_state == S_HALT));

  // State, retired-instruction counter and halt flag.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= S_INIT;
      instr_count <= 8'd0;
      halted      <= 1'b0;
    end else begin
      state  <= next_state;
      halted <= (next_state == S_HALT);
      if (retire) instr_count <= instr_count + 8'd1;
    end
  end

  assign SeqState   = state;
  assign InstrCount = instr_count;
  assign Halted     = halted;

  // Next-state and control decode.
  always_comb begin
    next_state  = state;
    RF_OutASel  = 3'b000;
    RF_OutBSel  = 3'b000;
    RF_FunSel   = 2'b00;
    RF_RSel     = 4'b0000;
    RF_TSel     = 4'b0000;
    ALU_FunSel  = 4'b0000;
    ARF_OutCSel = 2'b00;
    ARF_OutDSel = 2'b00;
    ARF_FunSel  = 2'b00;
    ARF_RegSel  = 4'b0000;
    IR_LH       = 1'b0;
    IR_Enable   = 1'b0;
    IR_Funsel   = 2'b00;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 1'b0;
    case (decode_state)
      S_INIT: begin
        RF_RSel    = 4'b1111;
        RF_FunSel  = 2'b11;
        ARF_RegSel = 4'b1110;
        ARF_FunSel = 2'b11;
        next_state = S_FETCH_L;
      end
      S_FETCH_L, S_FETCH_H: begin
        ARF_OutDSel = 2'b10;
        Mem_CS      = 1'b0;
        IR_Enable   = 1'b1;
        IR_LH       = (decode_state == S_FETCH_H);
        IR_Funsel   = 2'b10;
        ARF_RegSel  = 4'b1000;
        ARF_FunSel  = 2'b01;
        next_state  = (decode_state == S_FETCH_L) ? S_FETCH_H : S_EXEC0;
      end
      S_EXEC0: begin
        next_state = S_FETCH_L;
        case (opcode)
          OP_LDI: begin
            MuxASel   = 2'b10;
            RF_RSel   = rd_onehot;
            RF_FunSel = 2'b10;
          end
          OP_LDM, OP_STM: begin
            MuxBSel    = 2'b10;
            ARF_RegSel = 4'b0100;
            ARF_FunSel = 2'b10;
            next_state = S_EXEC1;
          end
          OP_ADD: begin
            RF_OutASel = {1'b1, rd};
            RF_OutBSel = {1'b1, rs};
            ALU_FunSel = 4'b0100;
            MuxASel    = 2'b00;
            RF_RSel    = rd_onehot;
            RF_FunSel  = 2'b10;
          end
          OP_BRA: begin
            MuxBSel    = 2'b10;
            ARF_RegSel = 4'b1000;
            ARF_FunSel = 2'b10;
          end
          OP_HLT:  next_state = S_HALT;
          default: next_state = S_FETCH_L;
        endcase
      end
      S_EXEC1: begin
        next_state  = S_FETCH_L;
        ARF_OutDSel = 2'b00;
        case (opcode)
          OP_LDM: begin
            Mem_CS    = 1'b0;
            MuxASel   = 2'b01;
            RF_RSel   = rd_onehot;
            RF_FunSel = 2'b10;
          end
          OP_STM: begin
            RF_OutASel = {1'b1, rd};
            MuxCSel    = 1'b0;
            ALU_FunSel = 4'b0000;
            Mem_CS     = 1'b0;
            Mem_WR     = 1'b1;
          end
          default: ;
        endcase
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_INIT;
    endcase
  end

endmodule
